// File: rtl/ysyx_25040111_mem_arb_if.sv
// Signal bundle between the icache refill port, the EXU data port and the shared LSU port.
// The arbiter takes the master view; the icache/EXU/LSU environment takes the slave view.
interface ysyx_25040111_mem_arb_if #(
  parameter int AW = 32
);
  logic          i_valid;
  logic [AW-1:0] i_addr;
  logic [7:0]    i_len;
  logic          i_burst;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          i_last;

  logic          d_valid;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [1:0]    d_mask;
  logic          d_rsign;
  logic          d_done;
  logic [31:0]   d_rdata;

  logic          m_valid;
  logic          m_ready;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_len;
  logic          m_burst;
  logic [31:0]   m_wdata;
  logic [1:0]    m_mask;
  logic          m_rsign;
  logic          m_rvalid;
  logic [31:0]   m_rdata;
  logic          m_rlast;
  logic          m_bvalid;

  logic          grant_d;

  modport master (
    input  i_valid, i_addr, i_len, i_burst,
    output i_rvalid, i_rdata, i_last,
    input  d_valid, d_write, d_addr, d_wdata, d_mask, d_rsign,
    output d_done, d_rdata,
    output m_valid, m_write, m_addr, m_len, m_burst, m_wdata, m_mask, m_rsign,
    input  m_ready, m_rvalid, m_rdata, m_rlast, m_bvalid,
    output grant_d
  );

  modport slave (
    output i_valid, i_addr, i_len, i_burst,
    input  i_rvalid, i_rdata, i_last,
    output d_valid, d_write, d_addr, d_wdata, d_mask, d_rsign,
    input  d_done, d_rdata,
    input  m_valid, m_write, m_addr, m_len, m_burst, m_wdata, m_mask, m_rsign,
    output m_ready, m_rvalid, m_rdata, m_rlast, m_bvalid,
    input  grant_d
  );
endinterface

// File: rtl/ysyx_25040111_mem_arb.sv
// Two-master arbiter sharing the LSU port between icache refills and EXU loads/stores.
// Data wins by default; a starvation counter forces an ifetch grant after STARVE_MAX data grants.
module ysyx_25040111_mem_arb #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input logic                       clock,
  input logic                       reset,
  ysyx_25040111_mem_arb_if.master   bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t        state_q;
  logic          grant_d_q;
  logic [3:0]    starve_q;
  logic          write_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    len_q;
  logic          burst_q;
  logic [31:0]   wdata_q;
  logic [1:0]    mask_q;
  logic          rsign_q;

  logic pick_d;
  logic resp_i;
  logic resp_d;
  logic d_complete;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pick_d = 1'b0;
    if (bus.d_valid && (!bus.i_valid || starve_q < STARVE_LIM)) pick_d = 1'b1;
  end

  // Request fields are captured at grant so the LSU sees a stable request even if the master moves on.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_d_q <= 1'b0;
      starve_q  <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= 1'b0;
      wdata_q   <= '0;
      mask_q    <= '0;
      rsign_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid || bus.d_valid) begin
            state_q   <= REQ;
            grant_d_q <= pick_d;
            if (pick_d) begin
              write_q  <= bus.d_write;
              addr_q   <= bus.d_addr;
              len_q    <= '0;
              burst_q  <= 1'b0;
              wdata_q  <= bus.d_wdata;
              mask_q   <= bus.d_mask;
              rsign_q  <= bus.d_rsign;
              starve_q <= bus.i_valid ? starve_q + 4'd1 : 4'd0;
            end else begin
              write_q  <= 1'b0;
              addr_q   <= bus.i_addr;
              len_q    <= bus.i_len;
              burst_q  <= bus.i_burst;
              wdata_q  <= '0;
              mask_q   <= 2'd2;
              rsign_q  <= 1'b0;
              starve_q <= '0;
            end
          end else begin
            starve_q <= '0;
          end
        end
        REQ: begin
          if (bus.m_ready) state_q <= RESP;
        end
        RESP: begin
          if (grant_d_q) begin
            if (d_complete) state_q <= IDLE;
          end else if (bus.m_rvalid && bus.m_rlast) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Responses are gated by reset so an aborted transaction never emits a late pulse.
  assign resp_i     = (state_q == RESP) && !grant_d_q && !reset;
  assign resp_d     = (state_q == RESP) &&  grant_d_q && !reset;
  assign d_complete = write_q ? bus.m_bvalid : bus.m_rvalid;

  assign bus.i_rvalid = resp_i && bus.m_rvalid;
  assign bus.i_rdata  = (resp_i && bus.m_rvalid) ? bus.m_rdata : 32'd0;
  assign bus.i_last   = resp_i && bus.m_rvalid && bus.m_rlast;

  assign bus.d_done   = resp_d && d_complete;
  assign bus.d_rdata  = (resp_d && !write_q && bus.m_rvalid) ? bus.m_rdata : 32'd0;

  assign bus.m_valid  = (state_q == REQ);
  assign bus.m_write  = bus.m_valid && write_q;
  assign bus.m_addr   = bus.m_valid ? addr_q  : '0;
  assign bus.m_len    = bus.m_valid ? len_q   : '0;
  assign bus.m_burst  = bus.m_valid && burst_q;
  assign bus.m_wdata  = bus.m_valid ? wdata_q : '0;
  assign bus.m_mask   = bus.m_valid ? mask_q  : '0;
  assign bus.m_rsign  = bus.m_valid && rsign_q;

  assign bus.grant_d  = (state_q != IDLE) && grant_d_q;
endmodule
